// File: rtl/relprime_pkg.sv
// Shared constants for the relprime engine datapath, controller and operand slices.
// Pure declarations: no logic, no latency, no flow control.
package relprime_pkg;

  localparam int DATA_W = 16;

  localparam logic [DATA_W-1:0] ZERO = '0;
  localparam logic [DATA_W-1:0] ONE  = DATA_W'(1);

endpackage

// File: rtl/datapath_section2_if.sv
// Operand/result bundle between the operand registers, this datapath slice and the controller.
// Unregistered wires; no handshake, the slice consumes operands every cycle.
interface datapath_section2_if
  import relprime_pkg::*;
#(
  parameter int WIDTH = DATA_W
);

  logic [WIDTH-1:0] a0;
  logic [WIDTH-1:0] a1out;
  logic             gcd_done;
  logic             compare;
  logic             relprime_done;
  logic [WIDTH-1:0] sub;

  modport master (
    output a0,
    output a1out,
    input  gcd_done,
    input  compare,
    input  relprime_done,
    input  sub
  );

  modport slave (
    input  a0,
    input  a1out,
    output gcd_done,
    output compare,
    output relprime_done,
    output sub
  );

endinterface

// File: rtl/datapath_section2_step.sv
// One subtraction-form Euclid step: magnitude difference, direction, zero/one detection.
// Purely combinational, zero latency; no backpressure.
module gcd_step_comb
  import relprime_pkg::*;
#(
  parameter int WIDTH = DATA_W
) (
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] a1out,
  output logic             compare,
  output logic [WIDTH-1:0] sub,
  output logic             gcd_done,
  output logic             relprime_done
);

  logic [WIDTH-1:0] diff_ab;
  logic [WIDTH-1:0] diff_ba;

  // Both subtractors run in parallel; the comparator picks the non-wrapping one.
  assign compare = (a0 > a1out);
  assign diff_ab = a0 - a1out;
  assign diff_ba = a1out - a0;
  assign sub     = compare ? diff_ab : diff_ba;

  assign gcd_done      = (a0 == WIDTH'(ZERO)) || (a1out == WIDTH'(ZERO));
  assign relprime_done = (a0 == WIDTH'(ONE))  || (a1out == WIDTH'(ONE));

endmodule

// File: rtl/datapath_section2.sv
// Euclid step slice with registered difference, direction and termination flags.
// Latency 1 cycle; no backpressure, inputs sampled on every rising edge.
module datapath_section2
  import relprime_pkg::*;
#(
  parameter int WIDTH = DATA_W
) (
  input  logic                clk,
  input  logic                rst_n,
  datapath_section2_if.slave  dp
);

  logic             step_compare;
  logic [WIDTH-1:0] step_sub;
  logic             step_gcd_done;
  logic             step_relprime_done;

  gcd_step_comb #(
    .WIDTH (WIDTH)
  ) u_step (
    .a0            (dp.a0),
    .a1out         (dp.a1out),
    .compare       (step_compare),
    .sub           (step_sub),
    .gcd_done      (step_gcd_done),
    .relprime_done (step_relprime_done)
  );

  // Register bank isolates the controller from the subtractor carry chain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dp.compare       <= 1'b0;
      dp.sub           <= '0;
      dp.gcd_done      <= 1'b0;
      dp.relprime_done <= 1'b0;
    end else begin
      dp.compare       <= step_compare;
      dp.sub           <= step_sub;
      dp.gcd_done      <= step_gcd_done;
      dp.relprime_done <= step_relprime_done;
    end
  end

endmodule

// File: tb/tb_datapath_section2.sv
// Table-driven, directed and randomized checks of the registered Euclid step slice.
module tb_datapath_section2;
  import relprime_pkg::*;

  localparam int W = DATA_W;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  datapath_section2_if #(.WIDTH(W)) dp ();

  datapath_section2 #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .dp    (dp)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  typedef struct {
    logic [W-1:0] a0;
    logic [W-1:0] a1;
    logic         cmp;
    logic [W-1:0] sub;
    logic         gcd;
    logic         rel;
  } vec_t;

  vec_t tbl [12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
  endtask

  task automatic check_all(input string tag, input logic cmp, input logic [W-1:0] s,
                           input logic g, input logic r);
    check({tag, ".compare"},       32'(dp.compare),       32'(cmp));
    check({tag, ".sub"},           32'(dp.sub),           32'(s));
    check({tag, ".gcd_done"},      32'(dp.gcd_done),      32'(g));
    check({tag, ".relprime_done"}, 32'(dp.relprime_done), 32'(r));
  endtask

  // Reference: signed difference in plain integer arithmetic, magnitude taken afterwards.
  task automatic model(input logic [W-1:0] a, input logic [W-1:0] b,
                       output logic cmp, output logic [W-1:0] s,
                       output logic g, output logic r);
    int d;
    d   = int'(a) - int'(b);
    cmp = (d > 0);
    s   = W'((d < 0) ? -d : d);
    g   = (a == 0) || (b == 0);
    r   = (a == 1) || (b == 1);
  endtask

  task automatic drive(input logic [W-1:0] a, input logic [W-1:0] b);
    dp.a0    = a;
    dp.a1out = b;
  endtask

  task automatic check_model(input string tag, input logic [W-1:0] a, input logic [W-1:0] b);
    logic cmp, g, r;
    logic [W-1:0] s;
    model(a, b, cmp, s, g, r);
    check_all(tag, cmp, s, g, r);
  endtask

  initial begin
    logic [W-1:0] ra, rb;

    tbl[0]  = '{16'd8,      16'd2,      1'b1, 16'd6,      1'b0, 1'b0};
    tbl[1]  = '{16'd3,      16'd10,     1'b0, 16'd7,      1'b0, 1'b0};
    tbl[2]  = '{16'd7,      16'd7,      1'b0, 16'd0,      1'b0, 1'b0};
    tbl[3]  = '{16'd0,      16'd16,     1'b0, 16'd16,     1'b1, 1'b0};
    tbl[4]  = '{16'd5,      16'd0,      1'b1, 16'd5,      1'b1, 1'b0};
    tbl[5]  = '{16'd1,      16'd5,      1'b0, 16'd4,      1'b0, 1'b1};
    tbl[6]  = '{16'd1,      16'd0,      1'b1, 16'd1,      1'b1, 1'b1};
    tbl[7]  = '{16'hFFFF,   16'd0,      1'b1, 16'hFFFF,   1'b1, 1'b0};
    tbl[8]  = '{16'd0,      16'd0,      1'b0, 16'd0,      1'b1, 1'b0};
    tbl[9]  = '{16'd0,      16'hFFFF,   1'b0, 16'hFFFF,   1'b1, 1'b0};
    tbl[10] = '{16'd1,      16'd1,      1'b0, 16'd0,      1'b0, 1'b1};
    tbl[11] = '{16'd2,      16'd1,      1'b1, 16'd1,      1'b0, 1'b1};

    // Reset held with live inputs and a running clock.
    drive(16'h1234, 16'h0001);
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_all("reset", 1'b0, '0, 1'b0, 1'b0);

    @(negedge clk);
    rst_n = 1'b1;

    foreach (tbl[i]) begin
      @(negedge clk);
      drive(tbl[i].a0, tbl[i].a1);
      @(posedge clk);
      #1;
      check_all($sformatf("vec%0d", i), tbl[i].cmp, tbl[i].sub, tbl[i].gcd, tbl[i].rel);
    end

    // Inputs changing between edges must not reach the outputs early.
    @(negedge clk);
    drive(16'd100, 16'd40);
    @(posedge clk);
    #1;
    drive(16'd3, 16'd9);
    #3;
    check_all("hold", 1'b1, 16'd60, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    check_all("next_edge", 1'b0, 16'd6, 1'b0, 1'b0);

    // Asynchronous clear between edges, then first edge after release.
    #1;
    rst_n = 1'b0;
    #1;
    check_all("async_rst", 1'b0, '0, 1'b0, 1'b0);
    @(negedge clk);
    check_all("rst_held", 1'b0, '0, 1'b0, 1'b0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_all("post_rst", 1'b0, 16'd6, 1'b0, 1'b0);

    for (int k = 0; k < 300; k++) begin
      case ($urandom_range(0, 3))
        0: begin
          ra = W'($urandom_range(0, 3));
          rb = W'($urandom_range(0, 3));
        end
        1: begin
          ra = W'($urandom);
          rb = ra;
        end
        default: begin
          ra = W'($urandom);
          rb = W'($urandom);
        end
      endcase
      @(negedge clk);
      drive(ra, rb);
      @(posedge clk);
      #1;
      check_model($sformatf("rnd%0d", k), ra, rb);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/datapath_section2.md
Name: datapath_section2

Overview:
Second datapath slice of the relative-prime (relprime) engine. It evaluates one step of the subtraction-form Euclid GCD on two operands: a0 (the current "a") and a1out (the current "b", taken from the a1 register output). It produces the magnitude difference, the direction flag for the controller, and GCD/relprime termination flags. Outputs are registered and feed the FSM controller and the operand-register write-back muxes.

Parameters:
WIDTH, 16, operand and difference width in bits (unsigned).

Ports:
clk  in  1  system clock, rising-edge active
rst_n  in  1  asynchronous active-low reset
a0  in  WIDTH  operand a, unsigned
a1out  in  WIDTH  operand b, unsigned
gcd_done  out  1  registered: GCD loop terminates this step
compare  out  1  registered: a0 > a1out, unsigned
relprime_done  out  1  registered: GCD has reached 1, so the operands are relatively prime
sub  out  WIDTH  registered: |a0 - a1out|

Behaviour:
- One clock, single clock domain. rst_n is asynchronous and active-low. On assertion, all outputs clear to 0 immediately: sub=0, compare=0, gcd_done=0, relprime_done=0.
- Latency is 1 cycle. Inputs are sampled on each rising clk edge. Outputs reflect the sampled inputs until the next edge. No handshake; the block evaluates every cycle.
- compare = (a0 > a1out), unsigned compare. When a0 == a1out, compare=0.
- sub = compare ? (a0 - a1out) : (a1out - a0). The result is always non-negative and never wraps. When a0 == a1out, sub=0. Full range is covered: a0=0xFFFF, a1out=0 gives sub=0xFFFF.
- gcd_done = (a0 == 0) || (a1out == 0). This covers both the Euclid early exit (a==0, result b) and the normal exit (b==0, result a).
- relprime_done = (a0 == 1) || (a1out == 1). Once either operand equals 1, the GCD is 1. This holds even if gcd_done is also 1 in the same cycle.
- a0 = a1out = 0: compare=0, sub=0, gcd_done=1, relprime_done=0.
- Reset deasserted mid-stream: the first rising edge after release registers the current inputs. No other state exists.
- No combinational path from inputs to outputs.

Decomposition:
- Shared package relprime_pkg holds:
  - the WIDTH default (16), as localparam DATA_W;
  - constants ZERO and ONE of width DATA_W, reused by controller and section1.
- One natural sub-module: gcd_step_comb. It is purely combinational and contains the comparator, the two subtractors with mux, and the zero/one detectors.
- The top level wraps gcd_step_comb with the async-reset output register bank.

Test Plan:
- Reset: hold rst_n=0 with arbitrary inputs -> all outputs 0. Assert rst_n mid-run -> outputs clear without waiting for a clk edge.
- a0=8, a1out=2, one clk -> compare=1, sub=6, gcd_done=0, relprime_done=0.
- a0=3, a1out=10 -> compare=0, sub=7, gcd_done=0, relprime_done=0. Then a0=a1out=7 -> compare=0, sub=0.
- a0=0, a1out=16 -> compare=0, sub=16, gcd_done=1, relprime_done=0. Then a0=5, a1out=0 -> compare=1, sub=5, gcd_done=1.
- a0=1, a1out=5 -> compare=0, sub=4, gcd_done=0, relprime_done=1. Then a0=1, a1out=0 -> gcd_done=1 and relprime_done=1.
- Extremes and latency: a0=0xFFFF, a1out=0 -> sub=0xFFFF, compare=1. Change inputs between edges -> outputs change only at the next rising clk edge.
